// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state and result encodings for the sequential comparator
package cmp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [2:0] {RES_NONE = 3'b000, RES_GT = 3'b100, RES_EQ = 3'b010, RES_LT = 3'b001} res_t;
endpackage

// File: rtl/seq_comparator_if.sv
// seq_comparator_if: launch handshake, operands and registered result flags
interface seq_comparator_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic signed_mode;
  logic busy;
  logic done;
  logic gt;
  logic eq;
  logic lt;
  modport master (output start, a, b, signed_mode, input busy, done, gt, eq, lt);
  modport slave (input start, a, b, signed_mode, output busy, done, gt, eq, lt);
endinterface

// File: rtl/cmp_bit_cell.sv
// cmp_bit_cell: one-bit magnitude slice; invert flips the sense for a sign bit
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert,
  output logic bit_gt,
  output logic bit_lt
);
  assign bit_gt = (a_bit ^ b_bit) & (a_bit ^ invert);
  assign bit_lt = (a_bit ^ b_bit) & ~(a_bit ^ invert);
endmodule

// File: rtl/seq_comparator.sv
// seq_comparator: bit-serial MSB-first magnitude compare with start/busy/done handshake
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic clk,
  input logic rst,
  seq_comparator_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  state_t state, next;
  logic [WIDTH-1:0] a_q, b_q;
  logic sm_q;
  logic [IW-1:0] idx;
  res_t dec, dec_now, res;
  logic bit_gt, bit_lt, last;
  cmp_bit_cell u_cell (
    .a_bit (a_q[idx]),
    .b_bit (b_q[idx]),
    .invert(sm_q && idx == IW'(WIDTH - 1)),
    .bit_gt(bit_gt),
    .bit_lt(bit_lt)
  );
  // RES_EQ doubles as "undecided" while scanning; the first difference sticks
  always_comb begin
    dec_now = dec != RES_EQ ? dec : bit_gt ? RES_GT : bit_lt ? RES_LT : RES_EQ;
    last = (EARLY_EXIT && dec_now != RES_EQ) || idx == '0;
    next = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res <= RES_NONE;
    end else begin
      state <= next;
      if (state == IDLE && bus.start) begin
        a_q <= bus.a;
        b_q <= bus.b;
        sm_q <= bus.signed_mode;
        idx <= IW'(WIDTH - 1);
        dec <= RES_EQ;
      end
      if (state == RUN) begin
        idx <= idx - 1'b1;
        dec <= dec_now;
        if (last) res <= dec_now;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign {bus.gt, bus.eq, bus.lt} = res;
endmodule

// File: tb/tb_seq_comparator.sv
// tb_seq_comparator: scoreboard bench driving an early-exit and a fixed-latency instance
module tb_seq_comparator;
  typedef struct {logic [2:0] res; int at; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int bc0 = 0;
  int bc1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  seq_comparator_if #(.WIDTH(8)) i0 ();
  seq_comparator_if #(.WIDTH(8)) i1 ();
  seq_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  seq_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  task automatic mon(input string n, input logic [2:0] flags, input int bc, ref exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected_done got=1 exp=0", n);
    end else begin
      e = q.pop_front();
      chk({n, "_flags"}, 32'(flags), 32'(e.res));
      chk({n, "_done_edge"}, 32'(cyc), 32'(e.at));
      chk({n, "_busy_cycles"}, 32'(bc), 32'(e.lat));
    end
  endtask
  always @(negedge clk) begin
    if (rst) bc0 = 0;
    else begin
      if (i0.busy) bc0++;
      if (i0.done) begin
        mon("u0", {i0.gt, i0.eq, i0.lt}, bc0, q0);
        bc0 = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (rst) bc1 = 0;
    else begin
      if (i1.busy) bc1++;
      if (i1.done) begin
        mon("u1", {i1.gt, i1.eq, i1.lt}, bc1, q1);
        bc1 = 0;
      end
    end
  end
  task automatic issue(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [2:0] res, input int lat, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while ((sel ? (i1.busy | i1.done) : (i0.busy | i0.done)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_wait got=busy exp=idle");
    end
    if (sel) begin
      i1.a = a; i1.b = b; i1.signed_mode = sm; i1.start = 1'b1;
    end else begin
      i0.a = a; i0.b = b; i0.signed_mode = sm; i0.start = 1'b1;
    end
    e.res = res;
    e.lat = lat;
    e.at = cyc + 1 + lat;
    if (push && sel) q1.push_back(e);
    if (push && !sel) q0.push_back(e);
    @(posedge clk);
    #1;
    if (sel) i1.start = 1'b0;
    else i0.start = 1'b0;
  endtask
  initial begin
    int n;
    i0.start = 1'b0; i0.a = '0; i0.b = '0; i0.signed_mode = 1'b0;
    i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_u1", 32'({i1.busy, i1.done, i1.gt, i1.eq, i1.lt}), 32'd0);
    chk("rst_u0", 32'({i0.busy, i0.done, i0.gt, i0.eq, i0.lt}), 32'd0);
    rst = 1'b0;
    issue(1, 8'hA5, 8'h5A, 0, 3'b100, 1, 1);
    repeat (4) @(negedge clk);
    chk("hold_gt", 32'({i1.busy, i1.gt, i1.eq, i1.lt}), 32'b0100);
    issue(1, 8'h3C, 8'h3C, 0, 3'b010, 8, 1);
    issue(1, 8'h80, 8'h01, 1, 3'b001, 1, 1);
    issue(1, 8'h80, 8'h01, 0, 3'b100, 1, 1);
    issue(1, 8'hFF, 8'h01, 1, 3'b001, 1, 1);
    issue(1, 8'h12, 8'h14, 0, 3'b001, 6, 1);
    issue(1, 8'hFE, 8'hFD, 1, 3'b100, 7, 1);
    issue(0, 8'h10, 8'h11, 0, 3'b001, 8, 1);
    repeat (2) @(negedge clk);
    i0.a = 8'hFF; i0.start = 1'b1;
    @(posedge clk);
    #1 i0.start = 1'b0;
    issue(0, 8'h7F, 8'h80, 1, 3'b100, 8, 1);
    issue(0, 8'h80, 8'h80, 1, 3'b010, 8, 1);
    issue(0, 8'h01, 8'h02, 0, 3'b001, 8, 1);
    issue(0, 8'h20, 8'h10, 0, 3'b000, 8, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_u0", 32'({i0.busy, i0.done, i0.gt, i0.eq, i0.lt}), 32'd0);
    rst = 1'b0;
    issue(0, 8'h20, 8'h10, 0, 3'b100, 8, 1);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d exp=0", q0.size() + q1.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
